// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: pops one word from the TX FIFO per frame and shifts it
// out as start bit, LSB-first data, optional parity and stop bit. Bit timing
// comes from an internal clocks-per-bit counter.
// Optional feature macro: UART_TX_PARITY_EN (adds one parity bit per frame).
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int WIDTH        = 8,
  parameter int PARITY_ODD   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo_not_empty,
  input  logic [WIDTH-1:0] fifo_r_data,
  output logic             fifo_rd_en,
  output logic             tx,
  output logic             tx_busy,
  output logic             tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd5,
`endif
    STOP   = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             rd_en_q, rd_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_end;

`ifdef UART_TX_PARITY_EN
  logic             par_q, par_d;
`else
  // Parity polarity has no effect in the 8N1 build.
  logic             unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
`endif

  assign bit_end = (cnt_q == CNT_MAX);

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE:  if (fifo_not_empty) state_d = FETCH;
      FETCH: state_d = LOAD;
      LOAD: begin
        // FIFO read data is valid here, one cycle after the pop.
        shift_d = fifo_r_data;
        cnt_d   = '0;
        idx_d   = '0;
`ifdef UART_TX_PARITY_EN
        par_d   = (^fifo_r_data) ^ (PARITY_ODD != 0);
`endif
        state_d = START;
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (idx_q == IDX_MAX) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = fifo_not_empty ? FETCH : IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    tx_d = 1'b1;
    case (state_d)
      START:  tx_d = 1'b0;
      DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
    rd_en_d = (state_d == FETCH);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == STOP) && (cnt_d == CNT_MAX);
  end

  // State and output registers; reset drops any in-flight word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      rd_en_q <= rd_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign tx         = tx_q;
  assign tx_busy    = busy_q;
  assign tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: two instances (4 and 2 clocks/bit)
// each fed by a small FIFO model; serial output is logged and decoded.
module tb_uart_tx_serializer;

  localparam int CPB1 = 4;
  localparam int CPB2 = 2;
  localparam int PO   = 0;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic clk, reset;
  int checks = 0;
  int errors = 0;

  // FIFO models
  logic [7:0] mem1 [0:15];
  logic [7:0] mem2 [0:15];
  int pushed1 = 0, pops1 = 0, under1 = 0;
  int pushed2 = 0, pops2 = 0, under2 = 0;
  logic [7:0] rd1 = '0, rd2 = '0;
  logic fne1, fne2, rden1, rden2, tx1, tx2, busy1, busy2, done1, done2;
  int done_cnt1 = 0, done_cnt2 = 0;

  assign fne1 = (pushed1 > pops1);
  assign fne2 = (pushed2 > pops2);

  uart_tx_serializer #(.CLKS_PER_BIT(CPB1), .WIDTH(8), .PARITY_ODD(PO)) u_dut1 (
    .clk(clk), .reset(reset), .fifo_not_empty(fne1), .fifo_r_data(rd1),
    .fifo_rd_en(rden1), .tx(tx1), .tx_busy(busy1), .tx_done(done1));

  uart_tx_serializer #(.CLKS_PER_BIT(CPB2), .WIDTH(8), .PARITY_ODD(PO)) u_dut2 (
    .clk(clk), .reset(reset), .fifo_not_empty(fne2), .fifo_r_data(rd2),
    .fifo_rd_en(rden2), .tx(tx2), .tx_busy(busy2), .tx_done(done2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rden1) begin
      if (pops1 >= pushed1) under1 <= under1 + 1;
      rd1   <= mem1[pops1 % 16];
      pops1 <= pops1 + 1;
    end
    if (rden2) begin
      if (pops2 >= pushed2) under2 <= under2 + 1;
      rd2   <= mem2[pops2 % 16];
      pops2 <= pops2 + 1;
    end
  end

  logic log1[$];
  logic log2[$];
  always @(negedge clk) begin
    log1.push_back(tx1);
    log2.push_back(tx2);
    if (done1 === 1'b1) done_cnt1 <= done_cnt1 + 1;
    if (done2 === 1'b1) done_cnt2 <= done_cnt2 + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected line level k cycles into a frame carrying byte b.
  function automatic logic ebit(input logic [7:0] b, input int k, input int cpb);
    int i;
    i = k / cpb;
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
    if (i == 9) return (^b) ^ (PO != 0);
`endif
    return 1'b1;
  endfunction

  // Reference receiver over a logged waveform.
  logic lg[$];
  logic [7:0] dec_vals[$];
  int dec_starts[$];
  int dec_bad;
  task automatic decode(input int cpb, input int from);
    int i;
    logic v;
    logic [15:0] bits;
    dec_vals.delete();
    dec_starts.delete();
    dec_bad = 0;
    i = from + 1;
    while (i < lg.size()) begin
      if (lg[i] === 1'b0 && lg[i-1] === 1'b1) begin
        if (i + NB * cpb > lg.size()) begin
          dec_bad++;
          break;
        end
        bits = '0;
        for (int j = 0; j < NB; j++) begin
          v = lg[i + j * cpb];
          bits[j] = v;
          for (int c = 1; c < cpb; c++)
            if (lg[i + j * cpb + c] !== v) dec_bad++;
        end
        if (bits[0] !== 1'b0) dec_bad++;
        if (bits[NB-1] !== 1'b1) dec_bad++;
`ifdef UART_TX_PARITY_EN
        if (bits[9] !== ((^bits[8:1]) ^ (PO != 0))) dec_bad++;
`endif
        dec_vals.push_back(bits[8:1]);
        dec_starts.push_back(i);
        i = i + NB * cpb;
      end else begin
        i++;
      end
    end
  endtask

  logic [7:0] b;
  int bad, p0, d0, off;
  logic [7:0] exp3 [0:2];
  logic [7:0] exp4 [0:3];

  initial begin
    reset = 1'b1;
    tick(3);
    @(negedge clk);
    chk("rst_tx", tx1, 1);
    chk("rst_rd_en", rden1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_tx2", tx2, 1);
    reset = 1'b0;
    tick(1);

    // Empty FIFO: line must stay quiet
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx1 !== 1'b1 || rden1 !== 1'b0 || busy1 !== 1'b0) bad++;
    end
    chk("idle_quiet", bad, 0);
    chk("idle_no_pop", pops1, 0);
    tick(1);

    // Single byte 0xA5, cycle-exact
    b = 8'hA5;
    mem1[pushed1 % 16] = b;
    pushed1++;
    p0 = pops1;
    d0 = done_cnt1;
    @(negedge clk);
    chk("n0_idle_busy", busy1, 0);
    @(negedge clk);
    chk("fetch_rd_en", rden1, 1);
    chk("fetch_busy", busy1, 1);
    chk("fetch_tx", tx1, 1);
    @(negedge clk);
    chk("load_rd_en", rden1, 0);
    chk("load_tx", tx1, 1);
    for (int k = 0; k < NB * CPB1; k++) begin
      @(negedge clk);
      chk($sformatf("a5_tx_c%0d", k), tx1, ebit(b, k, CPB1));
      chk($sformatf("a5_done_c%0d", k), done1, (k == NB * CPB1 - 1));
    end
    @(negedge clk);
    chk("a5_end_busy", busy1, 0);
    chk("a5_end_tx", tx1, 1);
    chk("a5_pops", pops1 - p0, 1);
    chk("a5_done_cnt", done_cnt1 - d0, 1);
    tick(1);

    // Three back-to-back frames
    exp3[0] = 8'h00; exp3[1] = 8'hFF; exp3[2] = 8'h3C;
    off = log1.size();
    p0 = pops1;
    d0 = done_cnt1;
    for (int k = 0; k < 3; k++) begin
      mem1[pushed1 % 16] = exp3[k];
      pushed1++;
    end
    tick(3 * (NB * CPB1 + 2) + 12);
    lg = log1;
    decode(CPB1, off);
    chk("b2b_frames", dec_vals.size(), 3);
    for (int k = 0; k < 3 && k < dec_vals.size(); k++)
      chk($sformatf("b2b_val%0d", k), dec_vals[k], exp3[k]);
    for (int k = 0; k + 1 < dec_starts.size(); k++)
      chk($sformatf("b2b_gap%0d", k), dec_starts[k+1] - dec_starts[k], NB * CPB1 + 2);
    chk("b2b_framing", dec_bad, 0);
    chk("b2b_pops", pops1 - p0, 3);
    chk("b2b_done_cnt", done_cnt1 - d0, 3);
    chk("b2b_idle", busy1, 0);

    // Reset during data bit 3 of 0x55
    mem1[pushed1 % 16] = 8'h55;
    pushed1++;
    d0 = done_cnt1;
    repeat (3) @(negedge clk);
    repeat (17) @(negedge clk);
    chk("mid_tx_bit3", tx1, 0);
    chk("mid_busy", busy1, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_tx", tx1, 1);
    chk("mid_rst_busy", busy1, 0);
    chk("mid_rst_done", done1, 0);
    reset = 1'b0;
    tick(NB * CPB1);
    chk("mid_stay_idle", busy1, 0);
    chk("mid_no_done", done_cnt1 - d0, 0);
    off = log1.size();
    p0 = pops1;
    mem1[pushed1 % 16] = 8'h96;
    pushed1++;
    tick(NB * CPB1 + 10);
    lg = log1;
    decode(CPB1, off);
    chk("post_rst_frames", dec_vals.size(), 1);
    if (dec_vals.size() > 0) chk("post_rst_val", dec_vals[0], 8'h96);
    chk("post_rst_framing", dec_bad, 0);
    chk("post_rst_pops", pops1 - p0, 1);
    chk("underflow1", under1, 0);

    // 2 clocks/bit, continuously non-empty FIFO of 4 words
    exp4[0] = 8'h12; exp4[1] = 8'h34; exp4[2] = 8'hC3; exp4[3] = 8'h81;
    off = log2.size();
    for (int k = 0; k < 4; k++) begin
      mem2[pushed2 % 16] = exp4[k];
      pushed2++;
    end
    tick(4 * (NB * CPB2 + 2) + 12);
    lg = log2;
    decode(CPB2, off);
    chk("c2_frames", dec_vals.size(), 4);
    for (int k = 0; k < 4 && k < dec_vals.size(); k++)
      chk($sformatf("c2_val%0d", k), dec_vals[k], exp4[k]);
    for (int k = 0; k + 1 < dec_starts.size(); k++)
      chk($sformatf("c2_gap%0d", k), dec_starts[k+1] - dec_starts[k], NB * CPB2 + 2);
    chk("c2_framing", dec_bad, 0);
    chk("c2_pops", pops2, 4);
    chk("c2_done_cnt", done_cnt2, 4);
    chk("underflow2", under2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
